// File: rtl/main_memory_responder_pkg.sv
// Shared memory-system types (package mem_pkg) used by main_memory_responder, mem_array and memory_block.
// Word/address widths, the responder FSM state encoding and a block-address helper live here.
package mem_pkg;

    localparam int unsigned WORD_LEN    = 32;
    localparam int unsigned ADDRESS_LEN = 13;

    typedef logic [WORD_LEN-1:0]    word_t;
    typedef logic [ADDRESS_LEN-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        RD_XFER   = 2'd2,
        WR_COMMIT = 2'd3
    } mem_state_e;

    // Word address of beat 'beat' inside the block containing 'a'; low address bits are dropped.
    function automatic addr_t block_word(addr_t a, int unsigned words, int unsigned beat);
        return (a & ~addr_t'(words - 1)) | addr_t'(beat);
    endfunction

endpackage

// File: rtl/main_memory_responder_mem_array.sv
// mem_array: single-port synchronous RAM with a registered read port, 2**ADDRESS_LEN words.
// Words are stored XOR-ed with their own address, so the power-up-zero array reads back word i = i.
module mem_array
    import mem_pkg::*;
(
    input  logic  clk_i,
    input  logic  we_i,
    input  addr_t addr_i,
    input  word_t wdata_i,
    output word_t rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_LEN;

    word_t mem_q [DEPTH];
    word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i ^ word_t'(addr_i);
        end
        rdata_q <= mem_q[addr_i] ^ word_t'(addr_i);
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency backing store serving block reads and single-word writes.
// Define MEM_ACCESS_STATS_EN to add saturating rd_block_count / wr_word_count outputs.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_req,
    input  logic                           wr_req,
    input  addr_t                          req_addr,
    input  word_t                          wr_data,
    output logic                           busy,
    output logic                           rd_valid,
    output word_t                          rd_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] rd_beat,
    output logic                           rd_last,
    output logic                           wr_done
`ifdef MEM_ACCESS_STATS_EN
    ,
    output addr_t                          rd_block_count,
    output addr_t                          wr_word_count
`endif
);

    localparam int unsigned       BEAT_W    = $clog2(BLOCK_WORDS);
    localparam int unsigned       CNT_W     = 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] beat_nxt;
    addr_t             addr_q, addr_d;
    word_t             data_q, data_d;
    logic              is_wr_q, is_wr_d;

    logic  read_done;
    logic  commit;
    logic  ram_we;
    addr_t ram_addr;
    word_t ram_rdata;

    assign beat_nxt  = beat_q + 1'b1;
    assign read_done = (state_q == RD_XFER) && (beat_q == LAST_BEAT);
    assign commit    = (state_q == WAIT) && (cnt_q == '0) && is_wr_q;
    // The write lands on the edge that enters WR_COMMIT; a reset on that edge aborts it.
    assign ram_we    = commit && !rst;

    // The RAM read is registered, so the address always runs one beat ahead of rd_data.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        data_d   = data_q;
        is_wr_d  = is_wr_q;
        ram_addr = addr_q;
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    addr_d  = req_addr;
                    data_d  = wr_data;
                    is_wr_d = wr_req;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (is_wr_q) begin
                        state_d = WR_COMMIT;
                    end else begin
                        state_d  = RD_XFER;
                        beat_d   = '0;
                        ram_addr = block_word(addr_q, BLOCK_WORDS, 0);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_XFER: begin
                ram_addr = block_word(addr_q, BLOCK_WORDS, 32'(beat_nxt));
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_nxt;
                end
            end
            WR_COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        data_q  <= data_d;
        is_wr_q <= is_wr_d;
    end

    mem_array u_mem (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    assign busy     = (state_q != IDLE);
    assign rd_valid = (state_q == RD_XFER);
    assign rd_data  = rd_valid ? ram_rdata : '0;
    assign rd_beat  = beat_q;
    assign rd_last  = read_done;
    assign wr_done  = (state_q == WR_COMMIT);

`ifdef MEM_ACCESS_STATS_EN
    addr_t rd_cnt_q;
    addr_t wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (read_done && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (commit && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign rd_block_count = rd_cnt_q;
    assign wr_word_count  = wr_cnt_q;
`endif

endmodule
